// File: rtl/lite_mem_pkg.sv
// Shared widths and arbiter state encoding for the Lite scratch memory.
package lite_mem_pkg;

    localparam int unsigned LITE_ADDR_W = 5;
    localparam int unsigned LITE_DATA_W = 32;
    localparam int unsigned LITE_LANES  = 4;
    localparam int unsigned LITE_LANE_W = LITE_DATA_W / LITE_LANES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/lite_regbank.sv
// Single-port byte-lane scratch memory with separate registered read data per requester.
module lite_regbank
    import lite_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = LITE_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   we,
    input  logic [LITE_LANES-1:0]  wstrb,
    input  logic [LITE_DATA_W-1:0] wdata,
    input  logic                   re,
    input  logic                   rsel,
    output logic [LITE_DATA_W-1:0] host_rdata,
    output logic [LITE_DATA_W-1:0] fab_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [LITE_DATA_W-1:0] rd_word_c;
    logic [LITE_DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [LITE_DATA_W-1:0] fab_rdata_q, fab_rdata_d;

    for (genvar k = 0; k < LITE_LANES; k++) begin : g_lane
        logic [LITE_LANE_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && wstrb[k]) begin
                mem[addr] <= wdata[LITE_LANE_W*k +: LITE_LANE_W];
            end
        end

        assign rd_word_c[LITE_LANE_W*k +: LITE_LANE_W] = mem[addr];
    end

    // Read data is sampled with the pre-write array contents of the same edge.
    always_comb begin
        host_rdata_d = host_rdata_q;
        fab_rdata_d  = fab_rdata_q;
        if (re && !rsel) host_rdata_d = rd_word_c;
        if (re && rsel)  fab_rdata_d  = rd_word_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata_q <= '0;
            fab_rdata_q  <= '0;
        end else begin
            host_rdata_q <= host_rdata_d;
            fab_rdata_q  <= fab_rdata_d;
        end
    end

    assign host_rdata = host_rdata_q;
    assign fab_rdata  = fab_rdata_q;

endmodule

// File: rtl/lite_mem_arbiter.sv
// Shares the Lite scratch memory between the host (absolute priority) and one fabric requester.
module lite_mem_arbiter
    import lite_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = LITE_ADDR_W,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic              user_wren,
    input  logic [3:0]        user_wstrb,
    input  logic              user_rden,
    input  logic [31:0]       user_addr,
    input  logic [31:0]       user_wr_data,
    output logic [31:0]       user_rd_data,
    input  logic              fab_req,
    input  logic              fab_we,
    input  logic [ADDR_W-1:0] fab_addr,
    input  logic [3:0]        fab_wstrb,
    input  logic [31:0]       fab_wdata,
    output logic              fab_gnt,
    output logic              fab_rvalid,
    output logic [31:0]       fab_rdata,
    output logic              fab_starved
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_e        state_q, state_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [3:0]        req_wstrb_q, req_wstrb_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              rvalid_q, rvalid_d;
    logic              starved_q, starved_d;

    logic              host_acc_c;
    logic              fab_exec_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              mem_we_c;
    logic [3:0]        mem_wstrb_c;
    logic [31:0]       mem_wdata_c;
    logic              mem_re_c;
    logic              mem_rsel_c;
    logic              unused_addr_bits;

    assign host_acc_c       = user_wren | user_rden;
    assign fab_exec_c       = (state_q == PEND) && !host_acc_c;
    assign unused_addr_bits = ^{user_addr[31:ADDR_W+2], user_addr[1:0]};

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wstrb_q <= '0;
            req_wdata_q <= '0;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            starved_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wstrb_q <= req_wstrb_d;
            req_wdata_q <= req_wdata_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            starved_q   <= starved_d;
        end
    end

    // Next state, holding register capture and saturating wait counter.
    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wstrb_d = req_wstrb_q;
        req_wdata_d = req_wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fab_req) begin
                    req_we_d    = fab_we;
                    req_addr_d  = fab_addr;
                    req_wstrb_d = fab_wstrb;
                    req_wdata_d = fab_wdata;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (host_acc_c) begin
                    cnt_d = (cnt_q == CNT_W'(MAX_WAIT)) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = req_we_q ? IDLE : RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port mux and registered handshake outputs.
    always_comb begin
        gnt_d       = (state_q == IDLE) && fab_req;
        rvalid_d    = fab_exec_c && !req_we_q;
        starved_d   = (state_d == PEND) && (cnt_d == CNT_W'(MAX_WAIT));
        mem_addr_c  = user_addr[ADDR_W+1:2];
        mem_we_c    = user_wren;
        mem_wstrb_c = user_wstrb;
        mem_wdata_c = user_wr_data;
        mem_re_c    = user_rden;
        mem_rsel_c  = 1'b0;
        if (fab_exec_c) begin
            mem_addr_c  = req_addr_q;
            mem_we_c    = req_we_q;
            mem_wstrb_c = req_wstrb_q;
            mem_wdata_c = req_wdata_q;
            mem_re_c    = !req_we_q;
            mem_rsel_c  = 1'b1;
        end
    end

    lite_regbank #(
        .ADDR_W (ADDR_W)
    ) u_regbank (
        .clk        (user_clk),
        .rst_n      (user_rst_n),
        .addr       (mem_addr_c),
        .we         (mem_we_c),
        .wstrb      (mem_wstrb_c),
        .wdata      (mem_wdata_c),
        .re         (mem_re_c),
        .rsel       (mem_rsel_c),
        .host_rdata (user_rd_data),
        .fab_rdata  (fab_rdata)
    );

    assign fab_gnt     = gnt_q;
    assign fab_rvalid  = rvalid_q;
    assign fab_starved = starved_q;

endmodule
